// File: rtl/sd_reader_pkg.sv
// Shared constants for the SD sector reader: controller register map,
// ASR bit positions, error codes and the reader FSM state encoding.
package sd_reader_pkg;

    localparam logic [7:0]  BUF_BASE       = 8'd0;
    localparam logic [7:0]  REG_ARG        = 8'd139;
    localparam logic [7:0]  REG_CMD        = 8'd140;
    localparam logic [7:0]  REG_ASR        = 8'd141;
    localparam logic [31:0] CMD_READ_BLOCK = 32'd17;

    localparam int ASR_VALID   = 0;
    localparam int ASR_CONN    = 1;
    localparam int ASR_BUSY    = 2;
    localparam int ASR_TIMEOUT = 3;
    localparam int ASR_CRC     = 4;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_NO_CARD = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_CRC     = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHK,
        S_WARG,
        S_WCMD,
        S_POLL,
        S_RES,
        S_RBUF,
        S_PUSH,
        S_DONE,
        S_ERR
    } state_e;

endpackage

// File: rtl/sd_avm_access.sv
// Single-access Avalon-MM master: holds address/data/strobe through
// waitrequest and always leaves one idle cycle after a completed access.
module sd_avm_access
    import sd_reader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        write_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        avm_read_o,
    output logic        avm_write_o,
    output logic [7:0]  avm_address_o,
    output logic [31:0] avm_writedata_o,
    input  logic [31:0] avm_readdata_i,
    input  logic        avm_waitrequest_i
);

    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        active;

    assign active = rd_q | wr_q;

    // A new access is only accepted while no strobe is up, which
    // yields the idle cycle after every completion.
    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (active && !avm_waitrequest_i) begin
            rd_d = 1'b0;
            wr_d = 1'b0;
        end else if (!active && start_i) begin
            rd_d    = !write_i;
            wr_d    = write_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 8'd0;
            wdata_q <= 32'd0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign done_o          = active && !avm_waitrequest_i;
    assign rdata_o         = avm_readdata_i;
    assign avm_read_o      = rd_q;
    assign avm_write_o     = wr_q;
    assign avm_address_o   = addr_q;
    assign avm_writedata_o = wdata_q;

endmodule

// File: rtl/sd_sector_reader.sv
// Issues CMD17 to the SD controller, polls for completion and streams
// the 128-word sector buffer out on a valid/ready interface.
module sd_sector_reader
    import sd_reader_pkg::*;
#(
    parameter bit          BYTE_ADDR  = 1'b1,
    parameter logic [23:0] POLL_LIMIT = 24'd12_000_000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_req_valid,
    input  logic [31:0] i_req_lba,
    output logic        o_req_ready,
    output logic        o_avm_chip_select,
    output logic [7:0]  o_avm_address,
    output logic        o_avm_read,
    output logic        o_avm_write,
    output logic [3:0]  o_avm_byteenable,
    output logic [31:0] o_avm_writedata,
    input  logic [31:0] i_avm_readdata,
    input  logic        i_avm_waitrequest,
    output logic [31:0] o_data,
    output logic        o_data_valid,
    output logic        o_data_last,
    input  logic        i_data_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [1:0]  o_error_code
);

    state_e      state_q, state_d;
    logic [31:0] lba_q, lba_d;
    logic [6:0]  idx_q, idx_d;
    logic [23:0] poll_q, poll_d;
    logic [4:0]  asr_q, asr_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  code_q, code_d;

    logic        acc_start, acc_write, acc_done;
    logic [7:0]  acc_addr;
    logic [31:0] acc_wdata, acc_rdata;
    logic        avm_rd, avm_wr;
    logic [31:0] arg;
    logic [23:0] poll_inc;

    assign arg      = BYTE_ADDR ? {lba_q[22:0], 9'd0} : lba_q;
    assign poll_inc = (poll_q == '1) ? poll_q : poll_q + 24'd1;

    always_comb begin
        state_d   = state_q;
        lba_d     = lba_q;
        idx_d     = idx_q;
        poll_d    = poll_q;
        asr_d     = asr_q;
        data_d    = data_q;
        code_d    = code_q;
        acc_start = 1'b0;
        acc_write = 1'b0;
        acc_addr  = REG_ASR;
        acc_wdata = 32'd0;
        unique case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    lba_d   = i_req_lba;
                    code_d  = ERR_NONE;
                    poll_d  = 24'd0;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                acc_start = 1'b1;
                if (acc_done) begin
                    if (acc_rdata[ASR_CONN] && acc_rdata[ASR_VALID]) begin
                        state_d = S_WARG;
                    end else begin
                        code_d  = ERR_NO_CARD;
                        state_d = S_ERR;
                    end
                end
            end
            S_WARG: begin
                acc_start = 1'b1;
                acc_write = 1'b1;
                acc_addr  = REG_ARG;
                acc_wdata = arg;
                if (acc_done) state_d = S_WCMD;
            end
            S_WCMD: begin
                acc_start = 1'b1;
                acc_write = 1'b1;
                acc_addr  = REG_CMD;
                acc_wdata = CMD_READ_BLOCK;
                if (acc_done) state_d = S_POLL;
            end
            S_POLL: begin
                acc_start = 1'b1;
                if (acc_done) begin
                    poll_d = poll_inc;
                    if (!acc_rdata[ASR_BUSY]) begin
                        asr_d   = acc_rdata[4:0];
                        state_d = S_RES;
                    end else if (poll_inc >= POLL_LIMIT) begin
                        code_d  = ERR_TIMEOUT;
                        state_d = S_ERR;
                    end
                end
            end
            S_RES: begin
                if (asr_q[ASR_TIMEOUT]) begin
                    code_d  = ERR_TIMEOUT;
                    state_d = S_ERR;
                end else if (asr_q[ASR_CRC]) begin
                    code_d  = ERR_CRC;
                    state_d = S_ERR;
                end else begin
                    idx_d   = 7'd0;
                    state_d = S_RBUF;
                end
            end
            S_RBUF: begin
                acc_start = 1'b1;
                acc_addr  = BUF_BASE | {1'b0, idx_q};
                if (acc_done) begin
                    data_d  = acc_rdata;
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                if (i_data_ready) begin
                    if (idx_q == 7'd127) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 7'd1;
                        state_d = S_RBUF;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            lba_q   <= 32'd0;
            idx_q   <= 7'd0;
            poll_q  <= 24'd0;
            asr_q   <= 5'd0;
            data_q  <= 32'd0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            lba_q   <= lba_d;
            idx_q   <= idx_d;
            poll_q  <= poll_d;
            asr_q   <= asr_d;
            data_q  <= data_d;
            code_q  <= code_d;
        end
    end

    sd_avm_access u_acc (
        .clk_i             (i_clock),
        .rst_i             (i_reset),
        .start_i           (acc_start),
        .write_i           (acc_write),
        .addr_i            (acc_addr),
        .wdata_i           (acc_wdata),
        .done_o            (acc_done),
        .rdata_o           (acc_rdata),
        .avm_read_o        (avm_rd),
        .avm_write_o       (avm_wr),
        .avm_address_o     (o_avm_address),
        .avm_writedata_o   (o_avm_writedata),
        .avm_readdata_i    (i_avm_readdata),
        .avm_waitrequest_i (i_avm_waitrequest)
    );

    assign o_avm_read        = avm_rd;
    assign o_avm_write       = avm_wr;
    assign o_avm_chip_select = avm_rd | avm_wr;
    assign o_avm_byteenable  = (avm_rd | avm_wr) ? 4'hF : 4'h0;
    assign o_req_ready       = (state_q == S_IDLE);
    assign o_busy            = (state_q != S_IDLE);
    assign o_data            = data_q;
    assign o_data_valid      = (state_q == S_PUSH);
    assign o_data_last       = (state_q == S_PUSH) && (idx_q == 7'd127);
    assign o_done            = (state_q == S_DONE);
    assign o_error           = (state_q == S_ERR);
    assign o_error_code      = code_q;

endmodule

// File: tb/tb_sd_sector_reader.sv
// Randomized scoreboard bench for sd_sector_reader with a behavioural
// SD controller register model and an expectation model per request.
module tb_sd_sector_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid;
    logic [31:0] req_lba;
    logic        req_ready;
    logic        cs, rd, wr;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata, rdata;
    logic        wait_r = 1'b0;
    logic [31:0] data;
    logic        dvalid, dlast;
    logic        dready = 1'b1;
    logic        busy, done, err;
    logic [1:0]  code;

    logic        b_req_valid;
    logic [31:0] b_req_lba;
    logic        b_req_ready, b_cs, b_rd, b_wr, b_dvalid, b_dlast;
    logic        b_busy, b_done, b_err;
    logic [7:0]  b_addr;
    logic [3:0]  b_be;
    logic [31:0] b_wdata, b_rdata, b_data;
    logic [1:0]  b_code;

    sd_sector_reader #(.BYTE_ADDR(1'b1), .POLL_LIMIT(24'd8)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_req_valid(req_valid), .i_req_lba(req_lba), .o_req_ready(req_ready),
        .o_avm_chip_select(cs), .o_avm_address(addr),
        .o_avm_read(rd), .o_avm_write(wr), .o_avm_byteenable(be),
        .o_avm_writedata(wdata), .i_avm_readdata(rdata),
        .i_avm_waitrequest(wait_r),
        .o_data(data), .o_data_valid(dvalid), .o_data_last(dlast),
        .i_data_ready(dready), .o_busy(busy), .o_done(done),
        .o_error(err), .o_error_code(code)
    );

    sd_sector_reader #(.BYTE_ADDR(1'b0)) dut_b (
        .i_clock(clk), .i_reset(rst),
        .i_req_valid(b_req_valid), .i_req_lba(b_req_lba),
        .o_req_ready(b_req_ready),
        .o_avm_chip_select(b_cs), .o_avm_address(b_addr),
        .o_avm_read(b_rd), .o_avm_write(b_wr), .o_avm_byteenable(b_be),
        .o_avm_writedata(b_wdata), .i_avm_readdata(b_rdata),
        .i_avm_waitrequest(1'b0),
        .o_data(b_data), .o_data_valid(b_dvalid), .o_data_last(b_dlast),
        .i_data_ready(1'b1), .o_busy(b_busy), .o_done(b_done),
        .o_error(b_err), .o_error_code(b_code)
    );

    int checks = 0;
    int errors = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // SD controller register model
    logic [31:0] chk_asr_v = 32'h3;
    logic [31:0] final_asr_v = 32'h3;
    logic [31:0] buf_base = 32'h0;
    int busy_polls = 0;
    int asr_total = 0;
    int buf_total = 0;
    int asr_base = 0;
    int buf_start = 0;
    int cyc = 0;
    bit wr_rand = 1'b0;
    bit rdy_rand = 1'b0;
    int stall_at = -1;
    int stall_left = 0;
    int words_acc = 0;
    int ends_seen = 0;
    int b_ends = 0;

    always_comb begin
        rdata = 32'h0;
        if (addr == 8'd141) begin
            if (asr_total == asr_base) rdata = chk_asr_v;
            else if (asr_total - asr_base - 1 < busy_polls) rdata = 32'h7;
            else rdata = final_asr_v;
        end else if (addr < 8'd128) begin
            rdata = buf_base + 32'(addr);
        end
    end

    always_comb begin
        b_rdata = {24'h0, b_addr};
        if (b_addr == 8'd141) b_rdata = 32'h3;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd && !wait_r) begin
            if (addr == 8'd141) asr_total <= asr_total + 1;
            else if (addr < 8'd128) buf_total <= buf_total + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        wait_r = wr_rand ? ($urandom_range(0, 1) == 1) : 1'b0;
        if (stall_left > 0) begin
            dready = 1'b0;
            stall_left = stall_left - 1;
        end else if (stall_at >= 0 && words_acc == stall_at && dvalid) begin
            dready = 1'b0;
            stall_left = 19;
            stall_at = -1;
        end else begin
            dready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    logic [39:0] exp_wr[$];
    logic [32:0] exp_word[$];
    logic [2:0]  exp_end[$];
    logic [39:0] b_exp[$];

    // Monitor: stability rules plus scoreboard pops on each DUT output
    logic        p_stall = 0, p_comp = 0, p_hold = 0, p_rd = 0, p_wr = 0;
    logic [7:0]  p_addr = 0;
    logic [31:0] p_wdata = 0, p_data = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rd || wr) begin
                    check("one_strobe", {rd, wr} == 2'b11, 0);
                    check("byteenable", be, 4'hF);
                end
                if (p_stall) begin
                    check("stall_addr", addr, p_addr);
                    check("stall_wdata", wdata, p_wdata);
                    check("stall_strobe", {rd, wr}, {p_rd, p_wr});
                end
                if (p_comp) check("idle_gap", rd || wr, 0);
                if (p_hold) begin
                    check("hold_valid", dvalid, 1);
                    check("hold_data", data, p_data);
                end
                if (wr && !wait_r) begin
                    if (exp_wr.size() == 0) check("unexpected_write", {addr, wdata}, 0);
                    else check("avm_write", {addr, wdata}, exp_wr.pop_front());
                end
                if (dvalid && dready) begin
                    if (exp_word.size() == 0) check("unexpected_word", data, 0);
                    else check("stream_word", {dlast, data}, exp_word.pop_front());
                    words_acc++;
                end
                if (done || err) begin
                    if (exp_end.size() == 0) check("unexpected_end", {err, code}, 0);
                    else check("outcome", {err, code}, exp_end.pop_front());
                    ends_seen++;
                end
                if (b_wr) begin
                    if (b_exp.size() == 0) check("b_unexpected_write", {b_addr, b_wdata}, 0);
                    else check("b_avm_write", {b_addr, b_wdata}, b_exp.pop_front());
                end
                if (b_done || b_err) b_ends++;
            end
            p_stall = !rst && (rd || wr) && wait_r;
            p_comp  = !rst && (rd || wr) && !wait_r;
            p_hold  = !rst && dvalid && !dready;
            p_rd = rd;
            p_wr = wr;
            p_addr = addr;
            p_wdata = wdata;
            p_data = data;
        end
    end

    // Reference model: expected bus writes, words and outcome of one request
    task automatic run_txn(input logic [31:0] lba, input logic [31:0] chk,
                           input int bp, input logic [31:0] fin,
                           input logic [31:0] base, input bit wrr,
                           input bit rdr, input int stall, input int max_cyc);
        int exp_asr, exp_buf, n, e0, t0;
        logic [1:0] ecode;
        chk_asr_v = chk;
        busy_polls = bp;
        final_asr_v = fin;
        buf_base = base;
        wr_rand = wrr;
        rdy_rand = rdr;
        stall_at = stall;
        asr_base = asr_total;
        buf_start = buf_total;
        words_acc = 0;
        exp_buf = 0;
        ecode = 2'd0;
        if (!(chk[1] && chk[0])) begin
            exp_asr = 1;
            ecode = 2'd1;
        end else begin
            exp_wr.push_back({8'd139, lba[22:0], 9'd0});
            exp_wr.push_back({8'd140, 32'd17});
            if (bp >= 8) begin
                exp_asr = 9;
                ecode = 2'd2;
            end else begin
                exp_asr = bp + 2;
                if (fin[3]) ecode = 2'd2;
                else if (fin[4]) ecode = 2'd3;
                else begin
                    for (int i = 0; i < 128; i++)
                        exp_word.push_back({i == 127, base + 32'(i)});
                    exp_buf = 128;
                end
            end
        end
        exp_end.push_back({ecode != 2'd0, ecode});
        e0 = ends_seen;
        check("req_ready_before", req_ready, 1);
        req_lba = lba;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        req_lba = ~lba;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (ends_seen == e0 && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (ends_seen == e0) check("txn_timeout", 1, 0);
        if (max_cyc > 0) check("latency_ok", (cyc - t0) <= max_cyc, 1);
        check("asr_reads", asr_total - asr_base, exp_asr);
        check("buf_reads", buf_total - buf_start, exp_buf);
        check("leftover", exp_wr.size() + exp_word.size() + exp_end.size(), 0);
        check("ready_after", {req_ready, busy}, 2'b10);
        wr_rand = 1'b0;
        rdy_rand = 1'b0;
        stall_at = -1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [31:0] r;
        rst = 1'b1;
        req_valid = 1'b0;
        req_lba = 32'h0;
        b_req_valid = 1'b0;
        b_req_lba = 32'h0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {req_ready, busy}, 2'b10);
        check("rst_strobes", {rd, wr, cs, be}, 0);
        check("rst_stream", {dvalid, dlast, data}, 0);
        check("rst_status", {done, err, code}, 0);
        @(posedge clk);
        #1;

        run_txn(32'd5, 32'h0, 0, 32'h3, 32'h0, 0, 0, -1, 10);
        run_txn(32'd3, 32'h3, 4, 32'h3, 32'hA500_0000, 0, 0, -1, 0);

        b_exp.push_back({8'd139, 32'h0012_3456});
        b_exp.push_back({8'd140, 32'd17});
        b_req_lba = 32'h0012_3456;
        b_req_valid = 1'b1;
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        n = 0;
        while (b_ends == 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b_done_seen", b_ends, 1);
        check("b_leftover", b_exp.size(), 0);

        run_txn($urandom(), 32'h3, 1, 32'h3, $urandom(), 1, 0, 64, 0);
        run_txn($urandom(), 32'h3, 2, 32'h13, $urandom(), 1, 0, -1, 0);
        run_txn($urandom(), 32'h3, 0, 32'h0B, $urandom(), 0, 0, -1, 0);
        run_txn($urandom(), 32'h3, 100, 32'h3, $urandom(), 1, 0, -1, 0);
        run_txn($urandom(), 32'h3, 7, 32'h3, $urandom(), 1, 1, -1, 0);

        // Reset in the middle of the stream
        r = $urandom();
        chk_asr_v = 32'h3;
        busy_polls = 1;
        final_asr_v = 32'h3;
        buf_base = r;
        asr_base = asr_total;
        words_acc = 0;
        wr_rand = 1'b1;
        for (int i = 0; i < 128; i++) exp_word.push_back({i == 127, r + 32'(i)});
        exp_wr.push_back({8'd139, r[22:0], 9'd0});
        exp_wr.push_back({8'd140, 32'd17});
        req_lba = r;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (words_acc < 40 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reached_word40", words_acc >= 40, 1);
        rst = 1'b1;
        req_valid = 1'b1;
        exp_word.delete();
        exp_wr.delete();
        exp_end.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 1'b0;
        wr_rand = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", {req_ready, busy}, 2'b10);
        check("mid_rst_strobes", {rd, wr, cs, be}, 0);
        check("mid_rst_stream", {dvalid, dlast, data}, 0);
        check("mid_rst_status", {done, err, code}, 0);
        @(posedge clk);
        #1;
        run_txn($urandom(), 32'h3, 3, 32'h3, $urandom(), 1, 1, -1, 0);

        for (int k = 0; k < 4; k++) begin
            logic [31:0] fins [4];
            fins[0] = 32'h03;
            fins[1] = 32'h13;
            fins[2] = 32'h0B;
            fins[3] = 32'h1B;
            run_txn($urandom(), 32'($urandom_range(0, 3)), $urandom_range(0, 9),
                    fins[$urandom_range(0, 3)], $urandom(), 1, 1, -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_sector_reader.md
Name: sd_sector_reader

Overview:
- Avalon-MM master that sits directly upstream of the SD card controller slave and drives its register interface.
- Accepts a logical block address (LBA) request, checks card presence, and writes the argument and command registers for a single-block read (CMD17).
- Polls the auxiliary status register until the command completes, then reads the 512-byte buffer as 128 words.
- Emits the words on a valid/ready stream to downstream logic (DMA or parser) and reports completion or an error code.

Parameters:
- BYTE_ADDR, 1: 1 = argument is LBA*512 (standard-capacity cards, LBA[22:0] used); 0 = argument is the LBA unchanged (SDHC).
- POLL_LIMIT, 24'd12_000_000: maximum number of ASR polls before declaring a timeout.

Ports:
- i_clock  in  1  system clock, shared with the SD controller.
- i_reset  in  1  synchronous active-high reset.
- i_req_valid  in  1  sector read request.
- i_req_lba  in  32  block number; sampled when i_req_valid && o_req_ready.
- o_req_ready  out  1  high only in IDLE.
- o_avm_chip_select  out  1  asserted with every read or write.
- o_avm_address  out  8  word address into the controller register map.
- o_avm_read  out  1  Avalon read strobe.
- o_avm_write  out  1  Avalon write strobe.
- o_avm_byteenable  out  4  always 4'hF while a strobe is asserted, else 0.
- o_avm_writedata  out  32  write data.
- i_avm_readdata  in  32  read data; valid in the cycle read && !waitrequest.
- i_avm_waitrequest  in  1  slave stall.
- o_data  out  32  buffer word.
- o_data_valid  out  1  stream valid.
- o_data_last  out  1  high with word 127.
- i_data_ready  in  1  stream ready.
- o_busy  out  1  high whenever the FSM is not IDLE.
- o_done  out  1  one-cycle pulse on successful completion.
- o_error  out  1  one-cycle pulse on failure.
- o_error_code  out  2  valid with o_error: 1 = no card, 2 = timeout, 3 = CRC; holds its value until the next request.

Behaviour:
- Reset: FSM returns to IDLE on the next edge. All strobes, o_data_valid, o_data_last, o_done, o_error and o_error_code are 0; o_data is 0; o_req_ready is 1. Reset mid-transfer abandons any Avalon access in flight; the slave sees the strobes drop.
- Avalon access rules:
  - An access completes in the first cycle where the strobe is high and waitrequest is low.
  - Address, writedata and strobes are held stable while waitrequest is high.
  - At most one strobe is asserted at a time.
  - After each completed access, strobes are deasserted for at least one cycle.
- FSM states:
  - IDLE: on handshake, latch the LBA, clear o_error_code, go to CHK.
  - CHK: read ASR (address 141). If bit1 (connected) and bit0 (valid) are both set, go to WARG; otherwise go to ERR with code 1.
  - WARG: write the argument register (139) with BYTE_ADDR ? {lba[22:0],9'b0} : lba.
  - WCMD: write the command register (140) with 17.
  - POLL: repeatedly read ASR and increment the poll counter per completed read.
    - Bit2 (in progress) clear → go to RES with the ASR value kept.
    - Counter reaching POLL_LIMIT while bit2 is still set → ERR with code 2.
  - RES: if ASR bit3 is set → ERR with code 2; else if bit4 is set → ERR with code 3; else go to RBUF with word index 0.
  - RBUF: read address {1'b0, idx[6:0]}; on completion capture readdata into o_data and go to PUSH.
  - PUSH: assert o_data_valid, with o_data_last = (idx == 127).
    - On ready: if idx == 127 go to DONE; otherwise increment idx and return to RBUF.
    - o_data is held stable while valid is high and ready is low.
  - DONE: pulse o_done, return to IDLE.
  - ERR: pulse o_error, return to IDLE.
- Throughput: no more than one word per 2 cycles (stream stall-free and zero waitrequest); readdata is not forwarded combinationally.
- Counters:
  - idx is 7 bits and does not wrap past 127; termination is governed by the last-word check.
  - The poll counter is 24 bits and saturates.
- Boundary cases:
  - i_req_valid while busy is ignored.
  - A request in the same cycle as reset is dropped.
  - Stream backpressure of any length is tolerated.

Decomposition:
- Package sd_reader_pkg holds:
  - register word addresses: BUF_BASE 0, ARG 139, CMD 140, ASR 141;
  - command code CMD_READ_BLOCK 17;
  - ASR bit indices: VALID 0, CONN 1, BUSY 2, TIMEOUT 3, CRC 4;
  - error-code constants;
  - state enum.
- One sub-module, sd_avm_access: a single-access Avalon master handshake (start/rw/addr/wdata in; done/rdata out) that enforces the stability and one-idle-cycle rules.

Test Plan:
- Card absent (ASR = 0), request LBA 5 → exactly one ASR read, no writes, o_error with code 1 within 10 cycles, o_req_ready high again.
- BYTE_ADDR = 1, LBA 3, ASR busy for 4 polls, buffer word n = 32'hA500_0000+n → writes 139 ← 0x600 then 140 ← 17, then 128 stream words in order, last on word 127 (0xA500_007F), one o_done.
- BYTE_ADDR = 0, LBA 0x0012_3456 → argument written is 0x0012_3456.
- Random waitrequest (50%) plus i_data_ready low for 20 cycles at word 64 → address, writedata and o_data stable throughout the stalls, no duplicate or dropped words.
- Poll result ASR = 0x13 (CRC set) → error code 3, no buffer reads; ASR = 0x0B → code 2; POLL_LIMIT = 8 with busy stuck → code 2 after 8 polls.
- Reset asserted at word 40 → all outputs at reset values on the next edge; a fresh request afterwards completes normally.
